// File: rtl/rv_ctrl_pkg.sv
// Shared types, opcode map and encodings for the multi-cycle RV32I control unit.
// Also holds the opcode-to-class decoder and the per-class ALU operand selects.
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CLS_OP     = 4'd0,
      CLS_OPIMM  = 4'd1,
      CLS_LOAD   = 4'd2,
      CLS_STORE  = 4'd3,
      CLS_BRANCH = 4'd4,
      CLS_LUI    = 4'd5,
      CLS_AUIPC  = 4'd6,
      CLS_JAL    = 4'd7,
      CLS_JALR   = 4'd8
   } class_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;
   localparam logic [1:0] WB_IMM  = 2'd3;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

   typedef struct packed {
      logic   legal;
      class_e cls;
   } decode_t;

   function automatic decode_t decode_opcode(input logic [6:0] opc);
      decode_t d;
      d.legal = 1'b1;
      d.cls   = CLS_OP;
      case (opc)
         OPC_OP:     d.cls = CLS_OP;
         OPC_OPIMM:  d.cls = CLS_OPIMM;
         OPC_LOAD:   d.cls = CLS_LOAD;
         OPC_STORE:  d.cls = CLS_STORE;
         OPC_BRANCH: d.cls = CLS_BRANCH;
         OPC_LUI:    d.cls = CLS_LUI;
         OPC_AUIPC:  d.cls = CLS_AUIPC;
         OPC_JAL:    d.cls = CLS_JAL;
         OPC_JALR:   d.cls = CLS_JALR;
         default:    d.legal = 1'b0;
      endcase
      return d;
   endfunction

   // Returns {alu_a_sel, alu_b_sel}; LUI writes back the immediate, so its ALU result is unused.
   function automatic logic [1:0] alu_selects(input class_e cls);
      logic [1:0] s;
      case (cls)
         CLS_OP:                         s = 2'b00;
         CLS_AUIPC, CLS_JAL, CLS_BRANCH: s = 2'b11;
         default:                        s = 2'b01;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/rv_ctrl_mem_watchdog.sv
// Saturating wait counter shared by the instruction-fetch and data-access handshakes.
// expired is high while the counter sits at TIMEOUT_CYCLES; clear has priority over enable.
module rv_mem_watchdog
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB with a TRAP sink.
// State, instruction class and trap cause are registered; datapath controls decode from them.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       br_taken,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       ir_en,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       rf_we,
   output logic       pc_en,
   output logic       pc_sel,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic [1:0] wb_sel,
   output logic       retire,
   output logic       trap,
   output logic [1:0] trap_cause
);

   state_e     state_q, state_d;
   class_e     cls_q, cls_d;
   logic [1:0] cause_q, cause_d;

   logic    wd_clr;
   logic    wd_en;
   logic    wd_expired;
   decode_t dec;

   assign dec = decode_opcode(opcode);

   rv_mem_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Ready is tested before expiry so a late ready on the last allowed cycle still completes.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      cause_d = cause_q;
      wd_en   = 1'b0;
      case (state_q)
         FETCH: begin
            if (imem_ready) begin
               state_d = DECODE;
            end else if (wd_expired) begin
               state_d = TRAP;
               cause_d = CAUSE_IMEM_TO;
            end else begin
               wd_en = 1'b1;
            end
         end
         DECODE: begin
            cls_d = dec.cls;
            if (dec.legal) begin
               state_d = EXEC;
            end else begin
               state_d = TRAP;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         EXEC: begin
            case (cls_q)
               CLS_BRANCH:           state_d = FETCH;
               CLS_LOAD, CLS_STORE:  state_d = MEM;
               default:              state_d = WB;
            endcase
         end
         MEM: begin
            if (dmem_ready) begin
               state_d = (cls_q == CLS_STORE) ? FETCH : WB;
            end else if (wd_expired) begin
               state_d = TRAP;
               cause_d = CAUSE_DMEM_TO;
            end else begin
               wd_en = 1'b1;
            end
         end
         WB:      state_d = FETCH;
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   assign wd_clr = (state_d != state_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
         cls_q   <= CLS_OP;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cause_q <= cause_d;
      end
   end

   logic [1:0] sel;
   assign sel = alu_selects(cls_q);

   // Operand selects stay at their EXEC values through MEM and WB to keep address/target stable.
   always_comb begin
      imem_req  = 1'b0;
      ir_en     = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      pc_en     = 1'b0;
      pc_sel    = 1'b0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      wb_sel    = WB_ALU;
      retire    = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            ir_en    = imem_ready;
         end
         EXEC: begin
            alu_a_sel = sel[1];
            alu_b_sel = sel[0];
            if (cls_q == CLS_BRANCH) begin
               pc_en  = 1'b1;
               pc_sel = br_taken;
               retire = 1'b1;
            end
         end
         MEM: begin
            alu_a_sel = sel[1];
            alu_b_sel = sel[0];
            dmem_req  = 1'b1;
            dmem_we   = (cls_q == CLS_STORE);
            if (dmem_ready && (cls_q == CLS_STORE)) begin
               pc_en  = 1'b1;
               retire = 1'b1;
            end
         end
         WB: begin
            alu_a_sel = sel[1];
            alu_b_sel = sel[0];
            rf_we     = 1'b1;
            pc_en     = 1'b1;
            retire    = 1'b1;
            case (cls_q)
               CLS_LOAD:          wb_sel = WB_LOAD;
               CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
               CLS_LUI:           wb_sel = WB_IMM;
               default:           wb_sel = WB_ALU;
            endcase
            pc_sel = (cls_q == CLS_JAL) || (cls_q == CLS_JALR);
         end
         default: ;
      endcase
   end

   assign trap       = (state_q == TRAP);
   assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed-vector bench for rv_multicycle_ctrl with TIMEOUT_CYCLES=4.
// Each cycle drives inputs, compares the packed control word, then advances one clock.
module tb_rv_multicycle_ctrl;
   import rv_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       br_taken, imem_ready, dmem_ready;
   logic       imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel;
   logic       alu_a_sel, alu_b_sel, retire, trap;
   logic [1:0] wb_sel, trap_cause;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .br_taken   (br_taken),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .ir_en      (ir_en),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .rf_we      (rf_we),
      .pc_en      (pc_en),
      .pc_sel     (pc_sel),
      .alu_a_sel  (alu_a_sel),
      .alu_b_sel  (alu_b_sel),
      .wb_sel     (wb_sel),
      .retire     (retire),
      .trap       (trap),
      .trap_cause (trap_cause)
   );

   // Control word bit positions (hex masks).
   localparam logic [14:0] IREQ   = 15'h4000;
   localparam logic [14:0] IREN   = 15'h2000;
   localparam logic [14:0] DREQ   = 15'h1000;
   localparam logic [14:0] DWE    = 15'h0800;
   localparam logic [14:0] RFWE   = 15'h0400;
   localparam logic [14:0] PCEN   = 15'h0200;
   localparam logic [14:0] PCSEL  = 15'h0100;
   localparam logic [14:0] ASEL   = 15'h0080;
   localparam logic [14:0] BSEL   = 15'h0040;
   localparam logic [14:0] WB_LD  = 15'h0010;
   localparam logic [14:0] WB_P4  = 15'h0020;
   localparam logic [14:0] RET    = 15'h0008;
   localparam logic [14:0] TRP    = 15'h0004;
   localparam logic [14:0] C_ILL  = 15'h0001;
   localparam logic [14:0] C_IMEM = 15'h0002;
   localparam logic [14:0] C_DMEM = 15'h0003;
   localparam logic [14:0] NONE   = 15'h0000;
   localparam logic [6:0]  OPC_BAD = 7'b1111111;

   logic [14:0] obs;
   assign obs = {imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel,
                 alu_a_sel, alu_b_sel, wb_sel, retire, trap, trap_cause};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [6:0] opc, input logic br,
                      input logic ir, input logic dr, input logic rn, input logic [14:0] exp);
      opcode     = opc;
      br_taken   = br;
      imem_ready = ir;
      dmem_ready = dr;
      rst_n      = rn;
      #1;
      check_val(tag, {17'd0, obs}, {17'd0, exp});
      check_val({tag, "/excl"}, {30'd0, imem_req & dmem_req, rf_we & dmem_we}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      opcode = OPC_OPIMM; br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      cyc("reset", OPC_OPIMM, 0, 0, 0, 0, IREQ);
      $display("txn reset");

      // ADDI, zero-wait: retire on cycle 4
      cyc("addi_f", OPC_OPIMM, 0, 1, 1, 1, IREQ | IREN);
      cyc("addi_d", OPC_OPIMM, 0, 1, 1, 1, NONE);
      cyc("addi_e", OPC_OPIMM, 0, 1, 1, 1, BSEL);
      cyc("addi_w", OPC_OPIMM, 0, 1, 1, 1, RFWE | PCEN | BSEL | RET);
      $display("txn ADDI");

      // LW, dmem ready after 3 wait cycles: 8 cycles total
      cyc("lw_f",  OPC_LOAD, 0, 1, 0, 1, IREQ | IREN);
      cyc("lw_d",  OPC_LOAD, 0, 1, 0, 1, NONE);
      cyc("lw_e",  OPC_LOAD, 0, 1, 0, 1, BSEL);
      cyc("lw_m1", OPC_LOAD, 0, 1, 0, 1, DREQ | BSEL);
      cyc("lw_m2", OPC_LOAD, 0, 1, 0, 1, DREQ | BSEL);
      cyc("lw_m3", OPC_LOAD, 0, 1, 0, 1, DREQ | BSEL);
      cyc("lw_m4", OPC_LOAD, 0, 1, 1, 1, DREQ | BSEL);
      cyc("lw_w",  OPC_LOAD, 0, 1, 0, 1, RFWE | PCEN | BSEL | WB_LD | RET);
      $display("txn LW");

      cyc("beq1_f", OPC_BRANCH, 1, 1, 0, 1, IREQ | IREN);
      cyc("beq1_d", OPC_BRANCH, 1, 1, 0, 1, NONE);
      cyc("beq1_e", OPC_BRANCH, 1, 1, 0, 1, ASEL | BSEL | PCEN | PCSEL | RET);
      $display("txn BEQ taken");
      cyc("beq0_f", OPC_BRANCH, 0, 1, 0, 1, IREQ | IREN);
      cyc("beq0_d", OPC_BRANCH, 0, 1, 0, 1, NONE);
      cyc("beq0_e", OPC_BRANCH, 0, 1, 0, 1, ASEL | BSEL | PCEN | RET);
      $display("txn BEQ not taken");

      cyc("jal_f", OPC_JAL, 0, 1, 0, 1, IREQ | IREN);
      cyc("jal_d", OPC_JAL, 0, 1, 0, 1, NONE);
      cyc("jal_e", OPC_JAL, 0, 1, 0, 1, ASEL | BSEL);
      cyc("jal_w", OPC_JAL, 0, 1, 0, 1, RFWE | PCEN | PCSEL | ASEL | BSEL | WB_P4 | RET);
      $display("txn JAL");

      cyc("op_f", OPC_OP, 0, 1, 0, 1, IREQ | IREN);
      cyc("op_d", OPC_OP, 0, 1, 0, 1, NONE);
      cyc("op_e", OPC_OP, 0, 1, 0, 1, NONE);
      cyc("op_w", OPC_OP, 0, 1, 0, 1, RFWE | PCEN | RET);
      $display("txn ADD");

      cyc("sw_f", OPC_STORE, 0, 1, 1, 1, IREQ | IREN);
      cyc("sw_d", OPC_STORE, 0, 1, 1, 1, NONE);
      cyc("sw_e", OPC_STORE, 0, 1, 1, 1, BSEL);
      cyc("sw_m", OPC_STORE, 0, 1, 1, 1, DREQ | DWE | BSEL | PCEN | RET);
      $display("txn SW");

      // Illegal opcode: TRAP for 20 cycles, then one reset cycle
      cyc("ill_f", OPC_BAD, 0, 1, 1, 1, IREQ | IREN);
      cyc("ill_d", OPC_BAD, 0, 1, 1, 1, NONE);
      for (int i = 0; i < 20; i++) cyc("ill_trap", OPC_BAD, 0, 1, 1, 1, TRP | C_ILL);
      cyc("ill_rst", OPC_BAD, 0, 0, 0, 0, TRP | C_ILL);
      cyc("ill_post", OPC_OPIMM, 0, 0, 0, 1, IREQ);
      $display("txn illegal opcode");

      // imem never ready: 5 FETCH cycles then TRAP cause 2 (one FETCH already consumed above)
      for (int i = 0; i < 4; i++) cyc("ito_wait", OPC_OPIMM, 0, 0, 0, 1, IREQ);
      cyc("ito_trap", OPC_OPIMM, 0, 0, 0, 1, TRP | C_IMEM);
      cyc("ito_rst", OPC_OPIMM, 0, 0, 0, 0, TRP | C_IMEM);
      $display("txn imem timeout");

      // Ready on the 5th FETCH cycle wins over the timeout
      for (int i = 0; i < 4; i++) cyc("ilate_wait", OPC_OPIMM, 0, 0, 0, 1, IREQ);
      cyc("ilate_f", OPC_OPIMM, 0, 1, 0, 1, IREQ | IREN);
      cyc("ilate_d", OPC_OPIMM, 0, 0, 0, 1, NONE);
      cyc("ilate_e", OPC_OPIMM, 0, 0, 0, 1, BSEL);
      cyc("ilate_w", OPC_OPIMM, 0, 0, 0, 1, RFWE | PCEN | BSEL | RET);
      $display("txn imem late ready");

      // LW with dmem never ready: 5 MEM cycles then TRAP cause 3
      cyc("dto_f", OPC_LOAD, 0, 1, 0, 1, IREQ | IREN);
      cyc("dto_d", OPC_LOAD, 0, 1, 0, 1, NONE);
      cyc("dto_e", OPC_LOAD, 0, 1, 0, 1, BSEL);
      for (int i = 0; i < 5; i++) cyc("dto_m", OPC_LOAD, 0, 1, 0, 1, DREQ | BSEL);
      cyc("dto_trap", OPC_LOAD, 0, 1, 0, 1, TRP | C_DMEM);
      cyc("dto_rst", OPC_LOAD, 0, 0, 0, 0, TRP | C_DMEM);
      $display("txn dmem timeout");

      // SW interrupted by reset while dmem_req is high
      cyc("swr_f", OPC_STORE, 0, 1, 0, 1, IREQ | IREN);
      cyc("swr_d", OPC_STORE, 0, 1, 0, 1, NONE);
      cyc("swr_e", OPC_STORE, 0, 1, 0, 1, BSEL);
      cyc("swr_m", OPC_STORE, 0, 1, 0, 1, DREQ | DWE | BSEL);
      cyc("swr_rst", OPC_STORE, 0, 0, 0, 0, DREQ | DWE | BSEL);
      cyc("swr_post", OPC_STORE, 0, 0, 0, 1, IREQ);
      $display("txn SW reset mid-access");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
